oled_spi_tx: RTL and testbench

//  Byte-serial SPI transmitter for the on-board OLED. It sits downstream of the processor's

---
 rtl/oled_spi_tx_pkg.sv | 23 ++
 rtl/oled_spi_tx_if.sv | 10 +
 rtl/oled_byte_fifo.sv | 56 +++++
 rtl/oled_spi_tx.sv | 133 +++++++++++++
 tb/tb_oled_spi_tx.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/oled_spi_tx_pkg.sv
// Shared types and constants for the OLED SPI transmitter.
package oled_spi_tx_pkg;

  // Shifter FSM states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLow  = 2'd1,
    StHigh = 2'd2
  } tx_state_e;

  // D/C# encodings: command vs display-data byte.
  localparam logic OledCmd  = 1'b0;
  localparam logic OledData = 1'b1;

  localparam int unsigned DefClkDiv = 4;

  // One FIFO entry: D/C# flag plus the byte.
  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } oled_byte_t;

endpackage

// File: rtl/oled_spi_tx_if.sv
// Producer-side valid/ready byte channel into the OLED transmitter.
interface oled_spi_tx_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_dc;

  modport master (output in_valid, output in_data, output in_dc, input in_ready);
  modport slave (input in_valid, input in_data, input in_dc, output in_ready);
endinterface

// File: rtl/oled_byte_fifo.sv
// Small {dc,data} FIFO; head entry is visible combinationally on rd_data.
module oled_byte_fifo import oled_spi_tx_pkg::*; #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       sysclk,
  input  logic       cpu_reset,
  input  logic       push,
  input  oled_byte_t wr_data,
  input  logic       pop,
  output oled_byte_t rd_data,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Extra MSB on each pointer separates full from empty.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  oled_byte_t  mem_q [DEPTH];
  oled_byte_t  mem_d [DEPTH];
  logic        push_en, pop_en;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // Next-state for pointers and storage.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_en) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer registers flush on reset; storage contents need no reset.
  always_ff @(posedge sysclk) begin
    if (cpu_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/oled_spi_tx.sv
// Byte-serial SPI mode-3 transmitter for the OLED panel, MSB first.
module oled_spi_tx import oled_spi_tx_pkg::*; #(
  parameter int unsigned CLK_DIV = DefClkDiv,
  parameter int unsigned DEPTH   = 4
) (
  input  logic          sysclk,
  input  logic          cpu_reset,
  oled_spi_tx_if.slave  in_if,
  output logic          busy,
  output logic          oled_sclk,
  output logic          oled_sdin,
  output logic          oled_dc
);

  localparam int unsigned DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DcntLast = DW'(CLK_DIV - 1);

  tx_state_e     state_q, state_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          sclk_q, sclk_d;
  logic          sdin_q, sdin_d;
  logic          dc_q, dc_d;
  logic          busy_q, busy_d;

  logic       fifo_full, fifo_empty, push, pop, load;
  oled_byte_t head, wr_entry;

  assign in_if.in_ready = !fifo_full;
  assign push           = in_if.in_valid && !fifo_full;
  assign wr_entry       = '{dc: in_if.in_dc, data: in_if.in_data};

  oled_byte_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .sysclk   (sysclk),
    .cpu_reset(cpu_reset),
    .push     (push),
    .wr_data  (wr_entry),
    .pop      (pop),
    .rd_data  (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Shifter next-state: divider, bit counter, SCLK phase, and byte reload.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bcnt_d  = bcnt_q;
    dcnt_d  = dcnt_q;
    sclk_d  = sclk_q;
    sdin_d  = sdin_q;
    dc_d    = dc_q;
    load    = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        load = !fifo_empty;
      end
      StLow: begin
        if (dcnt_q == DcntLast) begin
          sclk_d  = 1'b1;
          dcnt_d  = '0;
          state_d = StHigh;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      StHigh: begin
        if (dcnt_q == DcntLast) begin
          if (bcnt_q != 3'd0) begin
            sclk_d  = 1'b0;
            shreg_d = {shreg_q[6:0], 1'b0};
            sdin_d  = shreg_q[6];
            bcnt_d  = bcnt_q - 3'd1;
            dcnt_d  = '0;
            state_d = StLow;
          end else if (!fifo_empty) begin
            // Next byte starts on this edge so there is no idle-high gap.
            load = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    if (load) begin
      pop     = 1'b1;
      sclk_d  = 1'b0;
      sdin_d  = head.data[7];
      dc_d    = head.dc;
      shreg_d = head.data;
      bcnt_d  = 3'd7;
      dcnt_d  = '0;
      state_d = StLow;
    end
    busy_d = push || (state_d != StIdle) || !fifo_empty;
  end

  // Shifter state and registered outputs.
  always_ff @(posedge sysclk) begin
    if (cpu_reset) begin
      state_q <= StIdle;
      shreg_q <= '0;
      bcnt_q  <= '0;
      dcnt_q  <= '0;
      sclk_q  <= 1'b1;
      sdin_q  <= 1'b0;
      dc_q    <= OledCmd;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bcnt_q  <= bcnt_d;
      dcnt_q  <= dcnt_d;
      sclk_q  <= sclk_d;
      sdin_q  <= sdin_d;
      dc_q    <= dc_d;
      busy_q  <= busy_d;
    end
  end

  assign oled_sclk = sclk_q;
  assign oled_sdin = sdin_q;
  assign oled_dc   = dc_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_oled_spi_tx.sv
// Bench for oled_spi_tx: timeline model checked every cycle plus directed literal checks.
module tb_oled_spi_tx;
  import oled_spi_tx_pkg::*;

  localparam int unsigned CD  = 4;
  localparam int unsigned DEP = 4;
  localparam int          CDI = 4;

  logic sysclk = 1'b0;
  logic cpu_reset = 1'b1;
  always #5 sysclk = ~sysclk;

  oled_spi_tx_if a_if ();
  oled_spi_tx_if b_if ();
  logic a_busy, a_sclk, a_sdin, a_dc;
  logic b_busy, b_sclk, b_sdin, b_dc;

  oled_spi_tx #(.CLK_DIV(CD), .DEPTH(DEP)) u_dut_a (
    .sysclk(sysclk), .cpu_reset(cpu_reset), .in_if(a_if),
    .busy(a_busy), .oled_sclk(a_sclk), .oled_sdin(a_sdin), .oled_dc(a_dc)
  );

  oled_spi_tx #(.CLK_DIV(1), .DEPTH(DEP)) u_dut_b (
    .sysclk(sysclk), .cpu_reset(cpu_reset), .in_if(b_if),
    .busy(b_busy), .oled_sclk(b_sclk), .oled_sdin(b_sdin), .oled_dc(b_dc)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Model: a queue of pending bytes and the cycle offset into the byte on the wire.
  logic [8:0] mq[$];
  logic [8:0] m_cur = '0;
  bit         m_act = 0;
  int         m_p = 0;
  logic       m_sclk = 1'b1, m_sdin = 1'b0, m_dc = 1'b0, m_busy = 1'b0;
  bit         m_push, rst_e;
  int         cyc = 0;

  // Receiver: samples sdin/dc on each rising SCLK of DUT A.
  int         rise_a = 0;
  logic       prev_sclk = 1'b1;
  logic [7:0] rx_sh = '0;
  int         rx_n = 0;
  logic [8:0] rx_q[$];

  always @(posedge sysclk) begin
    cyc++;
    rst_e  = cpu_reset;
    m_push = !rst_e && a_if.in_valid && (mq.size() < DEP);
    if (rst_e) begin
      mq.delete();
      m_act = 0; m_p = 0;
      m_sclk = 1'b1; m_sdin = 1'b0; m_dc = 1'b0; m_busy = 1'b0;
    end else begin
      if (m_act) begin
        m_p++;
        if (m_p == 16 * CDI) m_act = 0;
      end
      if (!m_act && mq.size() > 0) begin
        m_cur = mq.pop_front();
        m_act = 1;
        m_p = 0;
      end
      if (m_push) mq.push_back({a_if.in_dc, a_if.in_data});
      if (m_act) begin
        m_sclk = ((m_p / CDI) % 2) == 1;
        m_sdin = m_cur[7 - m_p / (2 * CDI)];
        m_dc   = m_cur[8];
      end
      m_busy = m_push || m_act || (mq.size() > 0);
    end
    #1;
    check("a_outputs{sclk,sdin,dc,busy,ready}",
          32'({a_sclk, a_sdin, a_dc, a_busy, a_if.in_ready}),
          32'({m_sclk, m_sdin, m_dc, m_busy, mq.size() < DEP}));
    if (rst_e) begin
      rx_n = 0;
    end else if (!prev_sclk && a_sclk) begin
      rise_a++;
      rx_sh = {rx_sh[6:0], a_sdin};
      rx_n++;
      if (rx_n == 8) begin
        rx_q.push_back({a_dc, rx_sh});
        rx_n = 0;
      end
    end
    prev_sclk = a_sclk;
  end

  // Offers one byte once ready, holds it across one edge; returns at the following negedge.
  task automatic push_a(input logic dc, input logic [7:0] d, output int edge_no);
    int k;
    k = 0;
    @(negedge sysclk);
    while (!a_if.in_ready && k < 2000) begin
      @(negedge sysclk);
      k++;
    end
    check("push_ready_wait", 32'(a_if.in_ready), 32'(1));
    a_if.in_valid = 1'b1; a_if.in_dc = dc; a_if.in_data = d;
    @(posedge sysclk);
    #2 edge_no = cyc;
    @(negedge sysclk);
    a_if.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output int drop_edge);
    int k;
    k = 0;
    do begin
      @(negedge sysclk);
      k++;
    end while (a_busy && k < bound);
    check("idle_within_bound", 32'(a_busy), 32'(0));
    drop_edge = cyc;
  endtask

  task automatic check_rx(input string name, input logic [8:0] exp[$]);
    check({name, "_count"}, 32'(rx_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++)
      check({name, "_byte"}, 32'(rx_q[i]), 32'(exp[i]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, d, r0, r1, i, k, first_block;
    bit acc;
    logic [8:0] exp[$];
    logic last_b;

    a_if.in_valid = 1'b0; a_if.in_dc = 1'b0; a_if.in_data = '0;
    b_if.in_valid = 1'b0; b_if.in_dc = 1'b0; b_if.in_data = '0;
    repeat (3) @(negedge sysclk);
    cpu_reset = 1'b0;

    // Reset state.
    check("rst_sclk", 32'(a_sclk), 32'(1));
    check("rst_sdin", 32'(a_sdin), 32'(0));
    check("rst_dc", 32'(a_dc), 32'(0));
    check("rst_busy", 32'(a_busy), 32'(0));
    check("rst_ready", 32'(a_if.in_ready), 32'(1));

    // 1: single command byte 0xAF, one-cycle latency, 64-cycle byte.
    rx_q.delete();
    push_a(1'b0, 8'hAF, t);
    check("t1_sclk_before_fall", 32'(a_sclk), 32'(1));
    @(posedge sysclk);
    #2;
    check("t1_sclk_falls_t+1", 32'(a_sclk), 32'(0));
    wait_idle(300, d);
    check("t1_busy_drop_edge", 32'(d - t), 32'(65));
    exp = '{9'h0AF};
    check_rx("t1_rx", exp);

    // 2: two bytes back-to-back, data then command.
    rx_q.delete();
    r0 = rise_a;
    @(negedge sysclk);
    a_if.in_valid = 1'b1; a_if.in_dc = 1'b1; a_if.in_data = 8'hA5;
    @(posedge sysclk);
    #2 t = cyc;
    @(negedge sysclk);
    a_if.in_dc = 1'b0; a_if.in_data = 8'h3C;
    @(negedge sysclk);
    a_if.in_valid = 1'b0;
    wait_idle(500, d);
    check("t2_span", 32'(d - t), 32'(1 + 32 * CDI));
    check("t2_rises", 32'(rise_a - r0), 32'(16));
    exp = '{9'h1A5, 9'h03C};
    check_rx("t2_rx", exp);

    // 3: six bytes offered continuously; backpressure once four are queued.
    rx_q.delete();
    i = 0; k = 0; first_block = -1;
    @(negedge sysclk);
    while (i < 6 && k < 3000) begin
      a_if.in_valid = 1'b1; a_if.in_dc = i[0]; a_if.in_data = 8'h60 + 8'(i);
      acc = a_if.in_ready;
      if (!acc && first_block < 0) first_block = i;
      @(negedge sysclk);
      k++;
      if (acc) i++;
    end
    a_if.in_valid = 1'b0;
    check("t3_all_accepted", 32'(i), 32'(6));
    check("t3_blocked_at_byte", 32'(first_block), 32'(5));
    wait_idle(1000, d);
    exp.delete();
    for (int j = 0; j < 6; j++) exp.push_back({j[0], 8'h60 + 8'(j)});
    check_rx("t3_rx", exp);

    // 4: reset in the middle of 0x81 with two bytes queued.
    rx_q.delete();
    r0 = rise_a;
    push_a(1'b0, 8'h81, t);
    push_a(1'b1, 8'h55, t);
    push_a(1'b0, 8'hAA, t);
    k = 0;
    while (rise_a - r0 < 3 && k < 200) begin
      @(negedge sysclk);
      k++;
    end
    check("t4_three_rises", 32'(rise_a - r0), 32'(3));
    repeat (7) @(negedge sysclk);
    cpu_reset = 1'b1;
    @(negedge sysclk);
    cpu_reset = 1'b0;
    check("t4_sclk", 32'(a_sclk), 32'(1));
    check("t4_busy", 32'(a_busy), 32'(0));
    check("t4_ready", 32'(a_if.in_ready), 32'(1));
    r1 = rise_a;
    repeat (80) @(negedge sysclk);
    check("t4_no_edges", 32'(rise_a - r1), 32'(0));
    check("t4_still_idle", 32'(a_busy), 32'(0));
    check("t4_rx_empty", 32'(rx_q.size()), 32'(0));

    // 5a: push coinciding with a pop at occupancy 2 keeps occupancy at 2.
    rx_q.delete();
    push_a(1'b0, 8'h01, t);
    a_if.in_valid = 1'b1; a_if.in_data = 8'h02;
    @(negedge sysclk);
    a_if.in_data = 8'h03;
    @(negedge sysclk);
    a_if.in_valid = 1'b0;
    while (cyc < t + 64) @(negedge sysclk);
    check("t5_ready_occ2", 32'(a_if.in_ready), 32'(1));
    a_if.in_valid = 1'b1; a_if.in_data = 8'h04;
    @(negedge sysclk);
    check("t5_ready_after_pushpop", 32'(a_if.in_ready), 32'(1));
    a_if.in_data = 8'h05;
    @(negedge sysclk);
    check("t5_ready_occ3", 32'(a_if.in_ready), 32'(1));
    a_if.in_data = 8'h06;
    @(negedge sysclk);
    a_if.in_valid = 1'b0;
    check("t5_full_occ4", 32'(a_if.in_ready), 32'(0));
    wait_idle(1000, d);
    exp.delete();
    for (int j = 1; j <= 6; j++) exp.push_back({1'b0, 8'(j)});
    check_rx("t5_rx", exp);

    // 5b: twenty bytes stream through a depth-4 FIFO, wrapping pointers.
    rx_q.delete();
    i = 0; k = 0;
    @(negedge sysclk);
    while (i < 20 && k < 3000) begin
      a_if.in_valid = 1'b1; a_if.in_dc = 1'b1; a_if.in_data = 8'(i);
      acc = a_if.in_ready;
      @(negedge sysclk);
      k++;
      if (acc) i++;
    end
    a_if.in_valid = 1'b0;
    check("t5b_all_accepted", 32'(i), 32'(20));
    wait_idle(2000, d);
    exp.delete();
    for (int j = 0; j < 20; j++) exp.push_back({1'b1, 8'(j)});
    check_rx("t5b_rx", exp);

    // 6: CLK_DIV=1 instance, byte 0x01 in 16 cycles with SCLK toggling every cycle.
    @(negedge sysclk);
    b_if.in_valid = 1'b1; b_if.in_dc = 1'b1; b_if.in_data = 8'h01;
    @(posedge sysclk);
    @(negedge sysclk);
    b_if.in_valid = 1'b0;
    last_b = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      @(posedge sysclk);
      #2;
      check("t6_sclk_toggle", 32'(b_sclk), 32'(j % 2 == 0));
      if (j % 2 == 0) last_b = b_sdin;
    end
    check("t6_last_bit", 32'(last_b), 32'(1));
    check("t6_busy_at_16", 32'(b_busy), 32'(1));
    @(posedge sysclk);
    #2;
    check("t6_busy_at_17", 32'(b_busy), 32'(0));
    check("t6_sclk_idle", 32'(b_sclk), 32'(1));
    check("t6_dc", 32'(b_dc), 32'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
